// File: rtl/cache_types_pkg.sv
// Shared cache-side types: line burst FSM states and beat-count constants.
package cache_types_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } burst_state_e;

    localparam int BEAT_COUNT = 4;
    localparam int BEAT_CNT_W = 2;

endpackage

// File: rtl/line_burst_adapter.sv
// Converts one cache line request into a burst of BEAT_COUNT beats and back.
// Optional LINE_BURST_ADAPTER_PERF_EN adds perf_reads/perf_writes line counters.
module line_burst_adapter
    import cache_types_pkg::*;
#(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_beat   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pmem_address,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [s_line-1:0] pmem_wdata,
    output logic [s_line-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic [31:0]       burst_address,
    output logic              burst_read,
    output logic              burst_write,
    output logic [s_beat-1:0] burst_wdata,
    input  logic [s_beat-1:0] burst_rdata,
    input  logic              burst_resp
`ifdef LINE_BURST_ADAPTER_PERF_EN
    ,
    output logic [31:0]       perf_reads,
    output logic [31:0]       perf_writes
`endif
);

    localparam logic [31:0] OFFSET_MASK = (32'd1 << s_offset) - 32'd1;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEAT_COUNT - 1);

    burst_state_e state, next_state;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [31:0]           line_addr;
    logic [s_line-1:0]     line_data;
    logic                  in_burst;

    assign in_burst = (state == RD_BURST) || (state == WR_BURST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Write takes priority over read when both are requested together.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pmem_write) begin
                    next_state = WR_BURST;
                end else if (pmem_read) begin
                    next_state = RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (burst_resp && (beat_cnt == LAST_BEAT)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign burst_read    = (state == RD_BURST);
    assign burst_write   = (state == WR_BURST);
    assign pmem_resp     = (state == DONE);
    assign burst_address = line_addr & ~OFFSET_MASK;
    assign burst_wdata   = line_data[s_beat*int'(beat_cnt) +: s_beat];

    // A stalled beat (burst_resp low) leaves counter and line data untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt   <= '0;
            line_addr  <= '0;
            line_data  <= '0;
            pmem_rdata <= '0;
        end else begin
            if (state == IDLE) begin
                if (pmem_write) begin
                    line_addr <= pmem_address;
                    line_data <= pmem_wdata;
                end else if (pmem_read) begin
                    line_addr <= pmem_address;
                end
            end
            if (in_burst && burst_resp) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
                if (state == RD_BURST) begin
                    pmem_rdata[s_beat*int'(beat_cnt) +: s_beat] <= burst_rdata;
                end
            end
        end
    end

`ifdef LINE_BURST_ADAPTER_PERF_EN
    logic line_is_write;

    // Direction is remembered at request time so DONE knows which counter to bump.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_is_write <= 1'b0;
            perf_reads    <= '0;
            perf_writes   <= '0;
        end else begin
            if ((state == IDLE) && (pmem_write || pmem_read)) begin
                line_is_write <= pmem_write;
            end
            if (state == DONE) begin
                if (line_is_write) begin
                    perf_writes <= perf_writes + 32'd1;
                end else begin
                    perf_reads <= perf_reads + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench for line_burst_adapter: transaction-level model plus directed line transfers.
module tb_line_burst_adapter;

    localparam int BEATS = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  pmem_address = '0;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [255:0] pmem_wdata = '0;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata = '0;
    logic         burst_resp = 1'b0;
`ifdef LINE_BURST_ADAPTER_PERF_EN
    logic [31:0]  perf_reads;
    logic [31:0]  perf_writes;
`endif

    line_burst_adapter dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_address  (pmem_address),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
`ifdef LINE_BURST_ADAPTER_PERF_EN
        ,
        .perf_reads    (perf_reads),
        .perf_writes   (perf_writes)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks_total = 0;
    int checks_passed = 0;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // Line-transaction model: which line is in flight, how many beats have landed, whether it just finished.
    typedef enum {M_NONE, M_READ, M_WRITE} kind_t;
    kind_t       m_kind = M_NONE;
    int          m_beat = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_addr = '0;
    logic [63:0] m_wbeats [BEATS];
    logic [63:0] m_rbeats [BEATS];
    int          m_perf_r = 0;
    int          m_perf_w = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_kind = M_NONE;
            m_beat = 0;
            m_done = 1'b0;
            m_addr = '0;
            m_perf_r = 0;
            m_perf_w = 0;
            for (int k = 0; k < BEATS; k++) begin
                m_wbeats[k] = '0;
                m_rbeats[k] = '0;
            end
        end else if (m_done) begin
            if (m_kind == M_READ) m_perf_r++;
            else m_perf_w++;
            m_done = 1'b0;
            m_kind = M_NONE;
        end else if (m_kind == M_NONE) begin
            if (pmem_write) begin
                m_kind = M_WRITE;
                m_addr = pmem_address;
                for (int k = 0; k < BEATS; k++) m_wbeats[k] = pmem_wdata[64*k +: 64];
            end else if (pmem_read) begin
                m_kind = M_READ;
                m_addr = pmem_address;
            end
        end else if (burst_resp) begin
            if (m_kind == M_READ) m_rbeats[m_beat] = burst_rdata;
            m_beat++;
            if (m_beat == BEATS) begin
                m_beat = 0;
                m_done = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            checkOutput("burst_read", burst_read, (m_kind == M_READ) && !m_done);
            checkOutput("burst_write", burst_write, (m_kind == M_WRITE) && !m_done);
            checkOutput("pmem_resp", pmem_resp, m_done);
            checkOutput("burst_address", burst_address, m_addr & 32'hFFFF_FFE0);
            checkOutput("pmem_rdata", pmem_rdata, {m_rbeats[3], m_rbeats[2], m_rbeats[1], m_rbeats[0]});
            if ((m_kind == M_WRITE) && !m_done) checkOutput("burst_wdata", burst_wdata, m_wbeats[m_beat]);
`ifdef LINE_BURST_ADAPTER_PERF_EN
            checkOutput("perf_reads", perf_reads, m_perf_r);
            checkOutput("perf_writes", perf_writes, m_perf_w);
`endif
        end
    end

    logic [63:0] rd_beats [BEATS];
    int          res_latency;
    logic [31:0] res_addr;
    bit          res_saw_read;
    bit          res_saw_write;
    logic [63:0] res_wbeats [$];

    // Issue one line request and play the burst side, optionally stalling or resetting mid-line.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [255:0] line, input int stall_beat, input int stall_cycles,
                                 input int abort_after, input bit hold_done);
        int beats = 0;
        int stalled = 0;
        int start;
        bit finished = 1'b0;
        bit aborted = 1'b0;
        @(negedge clk);
        pmem_address = addr;
        pmem_wdata = line;
        pmem_write = wr;
        pmem_read = rd;
        burst_resp = 1'b0;
        start = cyc;
        res_latency = -1;
        res_addr = '0;
        res_saw_read = 1'b0;
        res_saw_write = 1'b0;
        res_wbeats.delete();
        for (int i = 0; i < 40 && !finished; i++) begin
            @(negedge clk);
            if (abort_after >= 0 && beats == abort_after) begin
                rst = 1'b0;
                #1;
                checkOutput("abort_burst_read", burst_read, 1'b0);
                checkOutput("abort_pmem_resp", pmem_resp, 1'b0);
                checkOutput("abort_pmem_rdata", pmem_rdata, '0);
                finished = 1'b1;
                aborted = 1'b1;
            end else if (pmem_resp) begin
                res_latency = cyc - start;
                finished = 1'b1;
            end else begin
                if (burst_read) res_saw_read = 1'b1;
                if (burst_write) res_saw_write = 1'b1;
                if (burst_read || burst_write) begin
                    res_addr = burst_address;
                    if (beats == stall_beat && stalled < stall_cycles) begin
                        burst_resp = 1'b0;
                        stalled++;
                    end else begin
                        burst_resp = 1'b1;
                        burst_rdata = rd_beats[beats];
                        if (burst_write) res_wbeats.push_back(burst_wdata);
                        beats++;
                    end
                end else begin
                    burst_resp = 1'b0;
                end
            end
        end
        checkOutput("line_completed", finished, 1'b1);
        if (hold_done && !aborted) @(negedge clk);
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        burst_resp = 1'b0;
        if (aborted) begin
            @(negedge clk);
            rst = 1'b1;
        end
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_burst_read", burst_read, 1'b0);
        checkOutput("reset_burst_write", burst_write, 1'b0);
        checkOutput("reset_pmem_resp", pmem_resp, 1'b0);
        checkOutput("reset_pmem_rdata", pmem_rdata, '0);
        checkOutput("reset_burst_address", burst_address, 32'h0);
        rst = 1'b1;

        // Beats offered while idle must not touch anything.
        @(negedge clk);
        burst_resp = 1'b1;
        burst_rdata = 64'hFFFF_0000_FFFF_0000;
        repeat (3) @(negedge clk);
        burst_resp = 1'b0;
        checkOutput("idle_resp_rdata", pmem_rdata, '0);

        rd_beats[0] = {8{8'h11}};
        rd_beats[1] = {8{8'h22}};
        rd_beats[2] = {8{8'h33}};
        rd_beats[3] = {8{8'h44}};
        applyStimulus(1'b0, 1'b1, 32'h0000_1234, '0, -1, 0, -1, 1'b0);
        checkOutput("rd_latency", res_latency, 5);
        checkOutput("rd_address", res_addr, 32'h0000_1220);
        checkOutput("rd_line", pmem_rdata, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
        checkOutput("rd_no_write", res_saw_write, 1'b0);

        applyStimulus(1'b1, 1'b0, 32'h0000_8000,
                      {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                       64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000}, -1, 0, -1, 1'b0);
        checkOutput("wr_latency", res_latency, 5);
        checkOutput("wr_address", res_addr, 32'h0000_8000);
        checkOutput("wr_beat_count", res_wbeats.size(), 4);
        checkOutput("wr_beat0", res_wbeats[0], 64'hDEAD_BEEF_0000_0000);
        checkOutput("wr_beat1", res_wbeats[1], 64'hDEAD_BEEF_0000_0001);
        checkOutput("wr_beat2", res_wbeats[2], 64'hDEAD_BEEF_0000_0002);
        checkOutput("wr_beat3", res_wbeats[3], 64'hDEAD_BEEF_0000_0003);
        checkOutput("wr_rdata_held", pmem_rdata, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});

        rd_beats[0] = 64'hA0A0_0000_0000_0001;
        rd_beats[1] = 64'hA1A1_0000_0000_0002;
        rd_beats[2] = 64'hA2A2_0000_0000_0003;
        rd_beats[3] = 64'hA3A3_0000_0000_0004;
        applyStimulus(1'b0, 1'b1, 32'h0000_2040, '0, 2, 3, -1, 1'b1);
        checkOutput("stall_latency", res_latency, 8);
        checkOutput("stall_line", pmem_rdata,
                    {64'hA3A3_0000_0000_0004, 64'hA2A2_0000_0000_0003,
                     64'hA1A1_0000_0000_0002, 64'hA0A0_0000_0000_0001});
        repeat (2) @(negedge clk);
        checkOutput("done_request_ignored", burst_read, 1'b0);

        applyStimulus(1'b1, 1'b1, 32'h0000_0040, {4{64'h5555_AAAA_5555_AAAA}}, -1, 0, -1, 1'b0);
        checkOutput("both_no_read", res_saw_read, 1'b0);
        checkOutput("both_write", res_saw_write, 1'b1);
        checkOutput("both_address", res_addr, 32'h0000_0040);

        applyStimulus(1'b0, 1'b1, 32'h0000_3000, '0, -1, 0, 2, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("abort_no_resp", pmem_resp, 1'b0);

        rd_beats[0] = 64'h0123_4567_89AB_CDEF;
        rd_beats[1] = 64'h1111_2222_3333_4444;
        rd_beats[2] = 64'h5555_6666_7777_8888;
        rd_beats[3] = 64'h9999_AAAA_BBBB_CCCC;
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, '0, -1, 0, -1, 1'b0);
        checkOutput("post_reset_latency", res_latency, 5);
        checkOutput("post_reset_line", pmem_rdata,
                    {64'h9999_AAAA_BBBB_CCCC, 64'h5555_6666_7777_8888,
                     64'h1111_2222_3333_4444, 64'h0123_4567_89AB_CDEF});

        applyStimulus(1'b1, 1'b0, 32'h0000_0200, {4{64'h0F0F_0F0F_0F0F_0F0F}}, -1, 0, -1, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0300, '0, -1, 0, -1, 1'b0);
        repeat (2) @(negedge clk);
`ifdef LINE_BURST_ADAPTER_PERF_EN
        checkOutput("perf_reads_total", perf_reads, 32'd2);
        checkOutput("perf_writes_total", perf_writes, 32'd1);
`endif

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
